nano_motion_sequencer: RTL and testbench
========================================

# nano_motion_sequencer

Command sequencer for the Nano drive train. It sits between the switch-decode logic and the motor driver/PWM pair. It accepts direction/speed commands through a valid/ready handshake and ramps PWM duty toward each target. Before any direction change it ramps to zero and holds a dead-time with all H-bridge inputs low, so the bridge never reverses under load. It produces the registered duty word for the PWM generator and the 4-bit bridge pattern for JA1..JA4.

## Interface
- RAMP_DIV, 1000: clock cycles per ramp step (≥1).
- RAMP_STEP, 4: duty change per ramp step (1..255).
- DEAD_CYCLES, 5000: cycles spent in DEAD with bridge off (≥1).
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_dir  in  2  direction code: 00 forward, 01 reverse, 10 left, 11 right.
- cmd_speed  in  3  speed level; 0 means stop.
- estop  in  1  emergency stop, level-sensitive, synchronous.
- duty  out  8  PWM duty for the PWM generator.
- drive  out  4  bridge pattern {JA1,JA2,JA3,JA4}.
- state  out  3  current state (debug/LEDs).
- busy  out  1  high when state is not IDLE and not RUN.

## Operation
- Target mapping: target = 0 when speed = 0; otherwise target = {cmd_speed, 5'b11111}. Speed 1 gives 63, speed 7 gives 255.
- Drive patterns: forward 1010, reverse 0101, left 0110, right 1001, off 0000.
- State encoding: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, DEAD=4.
- Handshake: cmd_ready = (state is IDLE or RUN) & ~estop & ~reset. A command is accepted on an edge where cmd_valid & cmd_ready.
- IDLE: duty = 0, drive = 0000.
  - Accepted command with speed ≠ 0: latch cur_dir and target, set drive to the new pattern, go to RAMP_UP.
  - Accepted command with speed = 0: consumed, stay in IDLE.
- RUN:
  - Same direction, target > duty: go to RAMP_UP.
  - Same direction, target < duty: go to RAMP_DOWN.
  - Same direction, target = duty: consumed, no state change.
  - Different direction: store pend_dir and pend_target, set target to 0, go to RAMP_DOWN.
  - Speed 0: set target to 0, go to RAMP_DOWN.
- RAMP_UP: on each ramp tick, duty ← min(duty + RAMP_STEP, target), computed at 9 bits with no wrap. When the new duty equals target, go to RUN on the same edge.
- RAMP_DOWN: on each ramp tick, duty ← max(duty − RAMP_STEP, target), computed with no underflow. When duty reaches target:
  - target = 0: go to DEAD.
  - otherwise: go to RUN.
- DEAD: drive = 0000, duty = 0; count DEAD_CYCLES cycles. Then:
  - pending command exists (pend_target ≠ 0): load drive from pend_dir, go to RAMP_UP toward pend_target, clear pending.
  - no pending command: go to IDLE.
- estop: on any edge with estop high, duty ← 0, drive ← 0000, pending cleared, state ← DEAD with the dead counter restarted.
  - While estop stays high, the block remains in DEAD with the counter held at 0.
  - After release, DEAD completes its full count and then goes to IDLE.
- Prescaler: counts 0..RAMP_DIV−1 only in RAMP_UP and RAMP_DOWN. It clears on entry to either ramp state. The ramp tick is the count RAMP_DIV−1.

## Timing
- Reset values: duty = 0, drive = 0000, state = IDLE, busy = 0, cmd_ready = 0 while reset is high. All counters and pending registers are 0.
- All outputs are registered except cmd_ready, which is decoded from state, estop and reset.
- Command accepted at edge k: state and drive update at edge k. The first duty step lands at edge k + RAMP_DIV; subsequent steps follow every RAMP_DIV cycles.
- Ramp 0→255 with defaults: 64 ticks (63 × 4 = 252, then saturate to 255).
- DEAD lasts exactly DEAD_CYCLES clock cycles, counted from the entry edge to the exit edge.
- Commands presented while busy are not accepted. The requester holds cmd_valid; acceptance happens on the first cycle in RUN or IDLE.
- estop has priority over a command accepted on the same edge; the command is discarded.
- Asynchronous reset mid-ramp or mid-DEAD forces all reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: RAMP_DIV=4, RAMP_STEP=64, DEAD_CYCLES=3.
- Forward start: after reset, send cmd forward/7. Required: drive = 1010 at the acceptance edge; duty steps 64, 128, 192, 255 at 4-cycle intervals; state = RUN on the edge where duty reaches 255; busy then drops.
- Reversal: from RUN forward/255, send reverse/3. Required: duty steps 191, 127, 63, 0; then DEAD with drive = 0000 for 3 cycles; then drive = 0101, duty steps 64, 127; state = RUN.
- Same-direction slowdown: from RUN forward/255, send forward/2 (target 95). Required: duty steps 191, 127, 95; state = RUN; DEAD is never entered; drive stays 1010.
- Estop: assert estop during RAMP_UP at duty = 128. Required: the next edge gives duty = 0, drive = 0000, state = DEAD; cmd_ready = 0 while estop is high; IDLE 3 cycles after release.
- Busy handshake: hold cmd_valid with left/7 during RAMP_DOWN. Required: cmd_ready = 0 and the command is not consumed; it is accepted only after RUN or IDLE is reached, then sequences through DEAD to drive = 0110.
- Async reset: assert reset mid-RUN between clock edges. Required: duty = 0, drive = 0000, state = 0 immediately; after release the block accepts a new command from IDLE.

Source files
------------

// File: rtl/nano_motion_sequencer.sv
// Drive-train command sequencer: ramps PWM duty toward each target, going through zero duty and a bridge-off dead time before any direction change.
// Outputs are registered and a command takes effect on its acceptance edge; cmd_ready is low except in IDLE or RUN, so commands are held off while ramping, in dead time or under estop.
module nano_motion_sequencer #(
   parameter int RAMP_DIV    = 1000,
   parameter int RAMP_STEP   = 4,
   parameter int DEAD_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_dir,
   input  logic [2:0] cmd_speed,
   input  logic       estop,
   output logic [7:0] duty,
   output logic [3:0] drive,
   output logic [2:0] state,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_RUN       = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_DEAD      = 3'd4
   } state_t;

   localparam int PW = $clog2(RAMP_DIV > 1 ? RAMP_DIV : 2);
   localparam int DW = $clog2(DEAD_CYCLES > 1 ? DEAD_CYCLES : 2);
   localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
   localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
   localparam logic [8:0]    STEP9      = 9'(RAMP_STEP);

   state_t          st_q, st_d;
   logic [7:0]      duty_q, duty_d;
   logic [3:0]      drive_q, drive_d;
   logic [1:0]      cur_dir_q, cur_dir_d;
   logic [7:0]      target_q, target_d;
   logic [1:0]      pend_dir_q, pend_dir_d;
   logic [7:0]      pend_target_q, pend_target_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [DW-1:0]   dead_q, dead_d;
   logic            busy_q, busy_d;

   logic            accept;
   logic            ramp_tick;
   logic [7:0]      cmd_target;
   logic [8:0]      up_sum;
   logic [7:0]      up_duty;
   logic [7:0]      dn_duty;

   function automatic logic [3:0] dir_pattern(input logic [1:0] d);
      case (d)
         2'b00:   dir_pattern = 4'b1010;
         2'b01:   dir_pattern = 4'b0101;
         2'b10:   dir_pattern = 4'b0110;
         default: dir_pattern = 4'b1001;
      endcase
   endfunction

   assign cmd_ready  = ((st_q == ST_IDLE) || (st_q == ST_RUN)) & ~estop & ~reset;
   assign accept     = cmd_valid & cmd_ready;
   assign cmd_target = (cmd_speed == 3'd0) ? 8'd0 : {cmd_speed, 5'b11111};
   assign ramp_tick  = (presc_q == PRESC_LAST);

   // Ramp arithmetic is done at 9 bits so the step saturates at the target instead of wrapping.
   assign up_sum  = {1'b0, duty_q} + STEP9;
   assign up_duty = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
   assign dn_duty = ({1'b0, duty_q} >= ({1'b0, target_q} + STEP9)) ? (duty_q - STEP9[7:0]) : target_q;

   always_comb begin
      st_d          = st_q;
      duty_d        = duty_q;
      drive_d       = drive_q;
      cur_dir_d     = cur_dir_q;
      target_d      = target_q;
      pend_dir_d    = pend_dir_q;
      pend_target_d = pend_target_q;
      presc_d       = '0;
      dead_d        = '0;

      case (st_q)
         ST_IDLE: begin
            duty_d  = 8'd0;
            drive_d = 4'b0000;
            if (accept && (cmd_target != 8'd0)) begin
               cur_dir_d = cmd_dir;
               target_d  = cmd_target;
               drive_d   = dir_pattern(cmd_dir);
               st_d      = ST_RAMP_UP;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (cmd_target == 8'd0) begin
                  target_d = 8'd0;
                  st_d     = ST_RAMP_DOWN;
               end else if (cmd_dir != cur_dir_q) begin
                  pend_dir_d    = cmd_dir;
                  pend_target_d = cmd_target;
                  target_d      = 8'd0;
                  st_d          = ST_RAMP_DOWN;
               end else if (cmd_target > duty_q) begin
                  target_d = cmd_target;
                  st_d     = ST_RAMP_UP;
               end else if (cmd_target < duty_q) begin
                  target_d = cmd_target;
                  st_d     = ST_RAMP_DOWN;
               end
            end
         end
         ST_RAMP_UP: begin
            if (ramp_tick) begin
               duty_d = up_duty;
               if (up_duty == target_q) st_d = ST_RUN;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         ST_RAMP_DOWN: begin
            if (ramp_tick) begin
               duty_d = dn_duty;
               if (dn_duty == target_q) begin
                  if (target_q == 8'd0) begin
                     st_d    = ST_DEAD;
                     drive_d = 4'b0000;
                  end else begin
                     st_d = ST_RUN;
                  end
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         ST_DEAD: begin
            duty_d  = 8'd0;
            drive_d = 4'b0000;
            if (dead_q == DEAD_LAST) begin
               if (pend_target_q != 8'd0) begin
                  drive_d       = dir_pattern(pend_dir_q);
                  cur_dir_d     = pend_dir_q;
                  target_d      = pend_target_q;
                  pend_dir_d    = 2'b00;
                  pend_target_d = 8'd0;
                  st_d          = ST_RAMP_UP;
               end else begin
                  st_d = ST_IDLE;
               end
            end else begin
               dead_d = dead_q + DW'(1);
            end
         end
         default: st_d = ST_IDLE;
      endcase

      // Emergency stop wins over everything, including a command accepted this edge.
      if (estop) begin
         st_d          = ST_DEAD;
         duty_d        = 8'd0;
         drive_d       = 4'b0000;
         target_d      = 8'd0;
         pend_dir_d    = 2'b00;
         pend_target_d = 8'd0;
         presc_d       = '0;
         dead_d        = '0;
      end

      busy_d = (st_d != ST_IDLE) && (st_d != ST_RUN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_q          <= ST_IDLE;
         duty_q        <= 8'd0;
         drive_q       <= 4'b0000;
         cur_dir_q     <= 2'b00;
         target_q      <= 8'd0;
         pend_dir_q    <= 2'b00;
         pend_target_q <= 8'd0;
         presc_q       <= '0;
         dead_q        <= '0;
         busy_q        <= 1'b0;
      end else begin
         st_q          <= st_d;
         duty_q        <= duty_d;
         drive_q       <= drive_d;
         cur_dir_q     <= cur_dir_d;
         target_q      <= target_d;
         pend_dir_q    <= pend_dir_d;
         pend_target_q <= pend_target_d;
         presc_q       <= presc_d;
         dead_q        <= dead_d;
         busy_q        <= busy_d;
      end
   end

   assign duty  = duty_q;
   assign drive = drive_q;
   assign state = st_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_nano_motion_sequencer.sv
// Directed bench for nano_motion_sequencer: expected output changes (with cycle spacing) are queued when a command is driven
// and popped each time the registered outputs change.
module tb_nano_motion_sequencer;
   logic       clock = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_dir;
   logic [2:0] cmd_speed;
   logic       estop;
   logic [7:0] duty;
   logic [3:0] drive;
   logic [2:0] state;
   logic       busy;

   nano_motion_sequencer #(.RAMP_DIV(4), .RAMP_STEP(64), .DEAD_CYCLES(3)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_speed(cmd_speed), .estop(estop),
      .duty(duty), .drive(drive), .state(state), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         delta;
      logic [2:0] st;
      logic [7:0] dt;
      logic [3:0] dr;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          since_chg = 0;
   logic [14:0] prev = 15'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic push(input int dl, input logic [2:0] st, input logic [7:0] dt, input logic [3:0] dr);
      exp_t e;
      e.delta = dl; e.st = st; e.dt = dt; e.dr = dr;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [1:0] d, input logic [2:0] s);
      cmd_dir   = d;
      cmd_speed = s;
      cmd_valid = 1'b1;
   endtask

   // One clock: drop cmd_valid after its acceptance edge and score any output change.
   task automatic step();
      logic        pend_acc;
      logic [14:0] cur;
      exp_t        e;
      pend_acc = cmd_valid && cmd_ready;
      @(negedge clock);
      since_chg++;
      if (pend_acc) cmd_valid = 1'b0;
      cur = {state, duty, drive};
      if (cur !== prev) begin
         chk("change_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("duty", 32'(duty), 32'(e.dt));
            chk("drive", 32'(drive), 32'(e.dr));
            chk("busy", 32'(busy), 32'((e.st != 3'd0) && (e.st != 3'd2)));
            if (e.delta != 0) chk("step_spacing", 32'(since_chg), 32'(e.delta));
         end
         prev      = cur;
         since_chg = 0;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1; estop = 1'b0; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_speed = 3'd0;
      @(negedge clock);
      @(negedge clock);
      chk("rst_duty", 32'(duty), 32'd0);
      chk("rst_drive", 32'(drive), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      #1 chk("idle_ready", 32'(cmd_ready), 32'd1);

      // Forward start to full speed.
      push(0, 3'd1, 8'd0, 4'b1010);
      push(4, 3'd1, 8'd64, 4'b1010);
      push(4, 3'd1, 8'd128, 4'b1010);
      push(4, 3'd1, 8'd192, 4'b1010);
      push(4, 3'd2, 8'd255, 4'b1010);
      send(2'b00, 3'd7);
      drain(200);

      // Reversal to speed 3 through dead time.
      push(0, 3'd3, 8'd255, 4'b1010);
      push(4, 3'd3, 8'd191, 4'b1010);
      push(4, 3'd3, 8'd127, 4'b1010);
      push(4, 3'd3, 8'd63, 4'b1010);
      push(4, 3'd4, 8'd0, 4'b0000);
      push(3, 3'd1, 8'd0, 4'b0101);
      push(4, 3'd1, 8'd64, 4'b0101);
      push(4, 3'd2, 8'd127, 4'b0101);
      send(2'b01, 3'd3);
      drain(200);

      // Back to forward full speed.
      push(0, 3'd3, 8'd127, 4'b0101);
      push(4, 3'd3, 8'd63, 4'b0101);
      push(4, 3'd4, 8'd0, 4'b0000);
      push(3, 3'd1, 8'd0, 4'b1010);
      push(4, 3'd1, 8'd64, 4'b1010);
      push(4, 3'd1, 8'd128, 4'b1010);
      push(4, 3'd1, 8'd192, 4'b1010);
      push(4, 3'd2, 8'd255, 4'b1010);
      send(2'b00, 3'd7);
      drain(200);

      // Same-direction slowdown, with a left command held while ramping down.
      push(0, 3'd3, 8'd255, 4'b1010);
      send(2'b00, 3'd2);
      drain(50);
      send(2'b10, 3'd7);
      #1 chk("busy_ready", 32'(cmd_ready), 32'd0);
      push(4, 3'd3, 8'd191, 4'b1010);
      push(4, 3'd3, 8'd127, 4'b1010);
      push(4, 3'd2, 8'd95, 4'b1010);
      push(1, 3'd3, 8'd95, 4'b1010);
      push(4, 3'd3, 8'd31, 4'b1010);
      push(4, 3'd4, 8'd0, 4'b0000);
      push(3, 3'd1, 8'd0, 4'b0110);
      push(4, 3'd1, 8'd64, 4'b0110);
      push(4, 3'd1, 8'd128, 4'b0110);
      push(4, 3'd1, 8'd192, 4'b0110);
      push(4, 3'd2, 8'd255, 4'b0110);
      drain(300);

      // Asynchronous reset mid-RUN, between clock edges.
      #2 reset = 1'b1;
      #1;
      chk("arst_duty", 32'(duty), 32'd0);
      chk("arst_drive", 32'(drive), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cmd_ready), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      prev = 15'd0;
      since_chg = 0;
      #1 chk("post_arst_ready", 32'(cmd_ready), 32'd1);

      // Restart forward, then estop at duty 128.
      push(0, 3'd1, 8'd0, 4'b1010);
      push(4, 3'd1, 8'd64, 4'b1010);
      push(4, 3'd1, 8'd128, 4'b1010);
      send(2'b00, 3'd7);
      drain(100);
      estop = 1'b1;
      #1 chk("estop_ready", 32'(cmd_ready), 32'd0);
      push(1, 3'd4, 8'd0, 4'b0000);
      drain(10);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("estop_hold_state", 32'(state), 32'd4);
         chk("estop_hold_ready", 32'(cmd_ready), 32'd0);
      end
      estop = 1'b0;
      push(6, 3'd0, 8'd0, 4'b0000);
      drain(20);

      // Estop on the same edge as a presented command discards the command.
      send(2'b00, 3'd7);
      estop = 1'b1;
      push(0, 3'd4, 8'd0, 4'b0000);
      drain(10);
      estop = 1'b0;
      cmd_valid = 1'b0;
      push(3, 3'd0, 8'd0, 4'b0000);
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
